// File: rtl/tone_sched_pkg.sv
// tone_sched_pkg: shared types and helpers for the tone scheduler.
// State encoding, default timing constants and a bus-slice helper.
package tone_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int TICK_DIV_DEF = 100000;  // clk cycles per ms at 100 MHz
  localparam int GAP_MS_DEF   = 10;

  // Widest flattened bus / field the slice helper handles.
  localparam int SL_BUS_W = 512;
  localparam int SL_W     = 32;

  // Field idx of width w from a flattened per-requester bus.
  function automatic logic [SL_W-1:0] slice_of(input logic [SL_BUS_W-1:0] bus,
                                               input int idx, input int w);
    logic [SL_BUS_W-1:0] sh;
    logic [SL_W-1:0]     mask;
    sh   = bus >> (idx * w);
    mask = (w >= SL_W) ? '1 : ((SL_W'(1) << w) - SL_W'(1));
    return sh[SL_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/tone_scheduler_divider.sv
// tone_divider: square-wave generator. Counts 0..half-1 and toggles the
// level on each wrap. Held cleared (count 0, level 0) while enable is low,
// and silent when half_period is 0.
module tone_divider #(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [HALF_W-1:0] half_period,
  output logic              level
);

  logic [HALF_W-1:0] r_cnt;
  logic              r_level;

  // Tone counter and level; cleared whenever not enabled or resting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!enable || (half_period == '0)) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_cnt == (half_period - 1'b1)) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler: fixed-priority sharing of the audio output between
// NUM_REQ tone requesters. Each grant plays one square-wave tone for a
// number of ms, then (with TONE_SCHED_GAP_EN defined) GAP_MS ms of silence
// with the amplifier still enabled.
// Build option: TONE_SCHED_GAP_EN enables the post-tone GAP state.
module tone_scheduler
  import tone_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int HALF_W   = 16,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int GAP_MS   = GAP_MS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*HALF_W-1:0] half_period,
  input  logic [NUM_REQ*DUR_W-1:0]  duration_ms,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      AUD_PWM,
  output logic                      AUD_SD
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_sel;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [HALF_W-1:0]   r_half;
  logic [DUR_W-1:0]    r_rem;
  logic [TICK_W-1:0]   r_tick;

  logic                w_any;
  logic [NUM_REQ-1:0]  w_pick;
  logic [HALF_W-1:0]   w_half;
  logic [DUR_W-1:0]    w_dur;
  logic                w_tick_wrap;
  logic                w_run_end;
  logic                w_play;
  logic                w_div_en;
  logic                w_level;

  // Lowest-index request wins; its operands are selected for latching.
  always_comb begin
    w_pick = '0;
    w_half = '0;
    w_dur  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
        w_half    = HALF_W'(slice_of(SL_BUS_W'(half_period), i, HALF_W));
        w_dur     = DUR_W'(slice_of(SL_BUS_W'(duration_ms), i, DUR_W));
      end
    end
  end

  assign w_any       = |req;
  assign w_tick_wrap = (r_tick == TICK_MAX);
  // A timed phase ends on the last tick of its last ms, or at once if 0 ms.
  assign w_run_end   = (r_rem == '0) || (w_tick_wrap && (r_rem == DUR_W'(1)));
  assign w_play      = (r_state == ST_PLAY);
  // Dropping enable on the final PLAY cycle forces the output low with done.
  assign w_div_en    = w_play && !w_run_end;

  // Arbitration, PLAY/GAP sequencing and the shared ms tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_half  <= '0;
      r_rem   <= '0;
      r_tick  <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_PLAY;
            r_sel   <= w_pick;
            r_grant <= w_pick;
            r_half  <= w_half;
            r_rem   <= w_dur;
            r_tick  <= '0;
          end
        end
        ST_PLAY: begin
          if (w_run_end) begin
            r_done <= r_sel;
`ifdef TONE_SCHED_GAP_EN
            r_state <= ST_GAP;
            r_rem   <= DUR_W'(GAP_MS);
            r_tick  <= '0;
`else
            r_state <= ST_IDLE;
`endif
          end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap) r_rem <= r_rem - 1'b1;
          end
        end
`ifdef TONE_SCHED_GAP_EN
        ST_GAP: begin
          if (w_run_end) begin
            r_state <= ST_IDLE;
          end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap) r_rem <= r_rem - 1'b1;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef TONE_SCHED_GAP_EN
  // GAP_MS only matters when the gap state is built in.
  logic w_unused_gap;
  assign w_unused_gap = (GAP_MS != 0);
`endif

  tone_divider #(.HALF_W(HALF_W)) u_div (
    .clk         (clk),
    .reset       (reset),
    .enable      (w_div_en),
    .half_period (r_half),
    .level       (w_level)
  );

  assign grant   = r_grant;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);
  assign AUD_SD  = busy;
  assign AUD_PWM = w_level;

endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: scoreboard bench for tone_scheduler (TICK_DIV=10,
// GAP_MS=2). Expected grant/done/AUD_PWM-edge events with their cycle
// numbers are queued when a request is driven and popped as the DUT
// produces them.
module tb_tone_scheduler;

  localparam int TD = 10;
`ifdef TONE_SCHED_GAP_EN
  localparam int GAPC = 2 * TD;
`else
  localparam int GAPC = 0;
`endif

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_PWM   = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] half_period;
  logic [31:0] duration_ms;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        busy;
  logic        AUD_PWM;
  logic        AUD_SD;

  ev_t  q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_pwm = 1'b0;

  tone_scheduler #(
    .NUM_REQ(2), .HALF_W(16), .DUR_W(16), .TICK_DIV(TD), .GAP_MS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .half_period (half_period),
    .duration_ms (duration_ms),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .AUD_PWM     (AUD_PWM),
    .AUD_SD      (AUD_SD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic obs_evt(input int kind, input int val);
    ev_t e;
    if (q.size() == 0) begin
      chk($sformatf("spurious_k%0d", kind), val, 0);
    end else begin
      e = q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk($sformatf("evt_val_k%0d", kind), val, e.val);
      chk($sformatf("evt_cyc_k%0d", kind), cyc, e.cyc);
    end
  endtask

  // One clock: sample outputs on the falling edge, then let the caller drive.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!reset) begin
      if (grant != 2'b00) obs_evt(K_GRANT, int'(grant));
      if (done != 2'b00)  obs_evt(K_DONE, int'(done));
      if (AUD_PWM != prev_pwm) obs_evt(K_PWM, int'(AUD_PWM));
      req = req & ~grant;  // requester drops its level once granted
    end
    prev_pwm = AUD_PWM;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic set_req(input int idx, input int h, input int d);
    half_period[idx*16 +: 16] = 16'(h);
    duration_ms[idx*16 +: 16] = 16'(d);
    req[idx] = 1'b1;
  endtask

  // Queue the events of one tone granted at cycle g; returns done cycle.
  task automatic exp_tone(input int idx, input int g, input int h, input int d,
                          output int dc);
    int len;
    int lvl;
    len = (d == 0) ? 1 : d * TD;
    lvl = 0;
    push(K_GRANT, 1 << idx, g);
    if (h > 0 && d > 0) begin
      for (int t = h; t < len; t += h) begin
        lvl = 1 - lvl;
        push(K_PWM, lvl, g + t);
      end
    end
    push(K_DONE, 1 << idx, g + len);
    if (lvl == 1) push(K_PWM, 0, g + len);
    dc = g + len;
  endtask

  initial begin
    int g, d0, d1;
    reset = 1'b1;
    req = '0;
    half_period = '0;
    duration_ms = '0;

    // Reset state
    run_cycles(2);
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pwm", int'(AUD_PWM), 0);
    chk("rst_sd", int'(AUD_SD), 0);
    reset = 1'b0;
    run_cycles(2);

    // Single request H=3, D=2
    set_req(0, 3, 2);
    g = cyc + 1;
    exp_tone(0, g, 3, 2, d0);
    run_cycles(10);
    chk("single_busy_mid", int'(busy), 1);
    chk("single_sd_mid", int'(AUD_SD), 1);
    run_until_empty(100);
    chk("single_busy_at_done", int'(busy), (GAPC > 0) ? 1 : 0);
    run_cycles(GAPC + 5);

    // Simultaneous requests: index 0 first, index 1 after done[0] (+gap)
    set_req(0, 2, 1);
    set_req(1, 3, 1);
    g = cyc + 1;
    exp_tone(0, g, 2, 1, d0);
    exp_tone(1, d0 + 1 + GAPC, 3, 1, d1);
    run_until_empty(200);
    run_cycles(GAPC + 5);

    // Rest tone H=0, D=1: silent, done after 10 cycles
    set_req(1, 0, 1);
    g = cyc + 1;
    exp_tone(1, g, 0, 1, d0);
    run_cycles(5);
    chk("rest_busy", int'(busy), 1);
    chk("rest_pwm", int'(AUD_PWM), 0);
    run_until_empty(100);
    run_cycles(GAPC + 5);

    // Zero duration: done one cycle after grant, no edge
    set_req(0, 5, 0);
    g = cyc + 1;
    exp_tone(0, g, 5, 0, d0);
    run_until_empty(50);
    run_cycles(GAPC + 5);

    // Withdrawn request: req[1] pulsed while busy is never served
    set_req(0, 4, 1);
    g = cyc + 1;
    exp_tone(0, g, 4, 1, d0);
    run_cycles(3);
    set_req(1, 2, 1);
    run_cycles(1);
    req[1] = 1'b0;
    run_until_empty(100);
    run_cycles(GAPC + 30);

    // Reset mid-PLAY: outputs drop immediately, no done for the aborted tone
    set_req(0, 2, 3);
    g = cyc + 1;
    push(K_GRANT, 1, g);
    push(K_PWM, 1, g + 2);
    push(K_PWM, 0, g + 4);
    push(K_PWM, 1, g + 6);
    run_until_empty(50);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pwm", int'(AUD_PWM), 0);
    chk("midrst_sd", int'(AUD_SD), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_grant", int'(grant), 0);
    run_cycles(2);
    reset = 1'b0;
    run_cycles(40);
    set_req(1, 3, 1);
    g = cyc + 1;
    exp_tone(1, g, 3, 1, d0);
    run_until_empty(100);
    run_cycles(GAPC + 5);

    // Maximum values: first toggle after 65535 cycles
    set_req(0, 16'hFFFF, 16'hFFFF);
    g = cyc + 1;
    push(K_GRANT, 1, g);
    push(K_PWM, 1, g + 65535);
    run_until_empty(70000);
    chk("max_busy", int'(busy), 1);
    chk("max_done", int'(done), 0);
    reset = 1'b1;
    run_cycles(2);
    chk("max_rst_busy", int'(busy), 0);
    reset = 1'b0;
    run_cycles(5);

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
